// File: rtl/apb_regbank_pkg.sv
// Shared types and helpers for the APB4 register bank: FSM state encoding,
// word-alignment constant and the register-index width function.
package apb_regbank_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } apb_state_e;

   localparam logic [1:0] BYTE_OFS_OK = 2'b00;

   // Minimum 1 so a single-register bank still gets a legal index vector.
   function automatic int clog2(input int n);
      int w;
      w = 1;
      while ((1 << w) < n) w++;
      return w;
   endfunction

endpackage

// File: rtl/apb_wait_counter.sv
// Access-phase wait-state counter for apb4_regbank. Only compiled and used
// when APB_REGBANK_WAIT_EN is defined; otherwise every access is zero-wait.
`ifdef APB_REGBANK_WAIT_EN
module apb_wait_counter
   import apb_regbank_pkg::*;
(
   input  logic       clk_sys,
   input  logic       rst_b,
   input  logic       clr,
   input  logic       en,
   input  logic [3:0] tc,
   output logic       done
);

   logic [3:0] cnt_d;
   logic [3:0] cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en && (cnt_q != tc)) begin
         cnt_d = cnt_q + 4'd1;
      end
   end

   always_ff @(posedge clk_sys or negedge rst_b) begin
      if (!rst_b) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign done = (cnt_q == tc);

endmodule
`endif

// File: rtl/apb4_regbank.sv
// APB4 leaf-slave register bank with byte strobes, RO status slots, write
// pulses and optional wait states (enabled by defining APB_REGBANK_WAIT_EN).
//
// state  | meaning
// IDLE   | no transfer in progress
// SETUP  | bus setup cycle; decoded from IDLE & PSEL & !PENABLE, captures address/error/read data
// ACCESS | access phase; waits for the counter, completes with PREADY
module apb4_regbank
   import apb_regbank_pkg::*;
#(
   parameter int                   DATA_WIDTH  = 32,
   parameter int                   ADDR_WIDTH  = 12,
   parameter int                   REG_COUNT   = 16,
   parameter logic [REG_COUNT-1:0] RO_MASK     = '0,
   parameter int                   WAIT_STATES = 0
) (
   input  logic                            PCLK,
   input  logic                            PRESETn,
   input  logic [ADDR_WIDTH-1:0]           PADDR,
   input  logic                            PSEL,
   input  logic                            PENABLE,
   input  logic                            PWRITE,
   input  logic [DATA_WIDTH-1:0]           PWDATA,
   input  logic [DATA_WIDTH/8-1:0]         PSTRB,
   output logic [DATA_WIDTH-1:0]           PRDATA,
   output logic                            PREADY,
   output logic                            PSLVERR,
   input  logic [REG_COUNT*DATA_WIDTH-1:0] hw_status,
   output logic [REG_COUNT*DATA_WIDTH-1:0] reg_q,
   output logic [REG_COUNT-1:0]            wr_pulse
);

   localparam int NBYTES = DATA_WIDTH / 8;
   localparam int IDX_W  = clog2(REG_COUNT);
   localparam int WIDX_W = ADDR_WIDTH - 2;
   localparam logic [WIDX_W-1:0] REG_LIMIT = WIDX_W'(REG_COUNT);

   if (((DATA_WIDTH % 8) != 0) || (WAIT_STATES < 0) || (WAIT_STATES > 15)) begin : g_param_chk
      $error("apb4_regbank: DATA_WIDTH must be a multiple of 8 and WAIT_STATES in 0..15");
   end

   apb_state_e            state_d, state_q, phase;
   logic                  err_d, err_q;
   logic [IDX_W-1:0]      idx_d, idx_q;
   logic [DATA_WIDTH-1:0] prdata_d, prdata_q;
   logic [REG_COUNT-1:0]  wr_pulse_d, wr_pulse_q;
   logic [DATA_WIDTH-1:0] regs_d [REG_COUNT];
   logic [DATA_WIDTH-1:0] regs_q [REG_COUNT];

   logic [WIDX_W-1:0] word_idx;
   logic [IDX_W-1:0]  idx_in;
   logic              in_range;
   logic              ro_hit;
   logic              setup_err;
   logic              wait_done;
   logic              pready;
   logic              wr_en;

   assign word_idx  = PADDR[ADDR_WIDTH-1:2];
   assign idx_in    = word_idx[IDX_W-1:0];
   assign in_range  = (word_idx < REG_LIMIT);
   assign ro_hit    = in_range && RO_MASK[idx_in];
   assign setup_err = !in_range || (PADDR[1:0] != BYTE_OFS_OK) || (PWRITE && ro_hit);

`ifdef APB_REGBANK_WAIT_EN
   apb_wait_counter u_wait (
      .clk_sys (PCLK),
      .rst_b   (PRESETn),
      .clr     (phase == SETUP),
      .en      (state_q == ACCESS),
      .tc      (4'(WAIT_STATES)),
      .done    (wait_done)
   );
`else
   assign wait_done = 1'b1;
`endif

   assign pready = (state_q == ACCESS) && PSEL && PENABLE && wait_done;
   assign wr_en  = pready && PWRITE && !err_q;

   // SETUP is never held in the register: the bus setup cycle is recognised
   // directly from IDLE so a zero-wait transfer takes exactly two cycles.
   always_comb begin
      phase = state_q;
      if ((state_q == IDLE) && PSEL && !PENABLE) begin
         phase = SETUP;
      end
      state_d = state_q;
      case (phase)
         IDLE:    state_d = IDLE;
         SETUP:   state_d = ACCESS;
         ACCESS:  if (!PSEL || pready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      err_d    = err_q;
      idx_d    = idx_q;
      prdata_d = prdata_q;
      if (phase == SETUP) begin
         err_d = setup_err;
         idx_d = idx_in;
         if (setup_err) begin
            prdata_d = '0;
         end else if (!PWRITE) begin
            prdata_d = ro_hit ? hw_status[idx_in*DATA_WIDTH +: DATA_WIDTH] : regs_q[idx_in];
         end
      end
   end

   always_comb begin
      regs_d     = regs_q;
      wr_pulse_d = '0;
      if (wr_en) begin
         wr_pulse_d[idx_q] = 1'b1;
         for (int k = 0; k < NBYTES; k++) begin
            if (PSTRB[k]) regs_d[idx_q][k*8 +: 8] = PWDATA[k*8 +: 8];
         end
      end
   end

   always_comb begin
      reg_q = '0;
      for (int i = 0; i < REG_COUNT; i++) begin
         reg_q[i*DATA_WIDTH +: DATA_WIDTH] = RO_MASK[i] ? '0 : regs_q[i];
      end
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state_q    <= IDLE;
         err_q      <= 1'b0;
         idx_q      <= '0;
         prdata_q   <= '0;
         wr_pulse_q <= '0;
         for (int i = 0; i < REG_COUNT; i++) regs_q[i] <= '0;
      end else begin
         state_q    <= state_d;
         err_q      <= err_d;
         idx_q      <= idx_d;
         prdata_q   <= prdata_d;
         wr_pulse_q <= wr_pulse_d;
         regs_q     <= regs_d;
      end
   end

   assign PRDATA   = prdata_q;
   assign PREADY   = pready;
   assign PSLVERR  = pready && err_q;
   assign wr_pulse = wr_pulse_q;

endmodule

// File: tb/tb_apb4_regbank.sv
// Scoreboard bench for apb4_regbank: transfers push expected responses, a
// negedge monitor pops them on PREADY and tracks expected write pulses.
module tb_apb4_regbank;

   localparam int DW = 32;
   localparam int AW = 12;
   localparam int RC = 16;
   localparam int WS = 3;
   localparam logic [RC-1:0] ROM = 16'h0008;
   localparam logic [DW-1:0] HW3 = 32'hCAFE0003;
`ifdef APB_REGBANK_WAIT_EN
   localparam int EXP_WS = WS;
`else
   localparam int EXP_WS = 0;
`endif

   logic            PCLK;
   logic            PRESETn;
   logic [AW-1:0]   PADDR;
   logic            PSEL;
   logic            PENABLE;
   logic            PWRITE;
   logic [DW-1:0]   PWDATA;
   logic [DW/8-1:0] PSTRB;
   logic [DW-1:0]   PRDATA;
   logic            PREADY;
   logic            PSLVERR;
   logic [RC*DW-1:0] hw_status;
   logic [RC*DW-1:0] reg_q;
   logic [RC-1:0]    wr_pulse;

   apb4_regbank #(
      .DATA_WIDTH  (DW),
      .ADDR_WIDTH  (AW),
      .REG_COUNT   (RC),
      .RO_MASK     (ROM),
      .WAIT_STATES (WS)
   ) dut (
      .PCLK      (PCLK),
      .PRESETn   (PRESETn),
      .PADDR     (PADDR),
      .PSEL      (PSEL),
      .PENABLE   (PENABLE),
      .PWRITE    (PWRITE),
      .PWDATA    (PWDATA),
      .PSTRB     (PSTRB),
      .PRDATA    (PRDATA),
      .PREADY    (PREADY),
      .PSLVERR   (PSLVERR),
      .hw_status (hw_status),
      .reg_q     (reg_q),
      .wr_pulse  (wr_pulse)
   );

   typedef struct {
      logic          wr;
      logic          err;
      logic [DW-1:0] rdata;
      logic [RC-1:0] pulse;
   } exp_t;

   exp_t          sb_q[$];
   int            n_vec = 0;
   int            n_err = 0;
   logic [DW-1:0] mdl [RC];
   logic [RC-1:0] exp_pulse = '0;

   initial PCLK = 1'b0;
   always #5 PCLK = ~PCLK;

   task automatic chk(input string tag, input logic [RC*DW-1:0] got, input logic [RC*DW-1:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, got, exp);
      end
   endtask

   function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] data,
                                            input logic [3:0] strb);
      logic [DW-1:0] r;
      r = old;
      for (int k = 0; k < 4; k++) if (strb[k]) r[k*8 +: 8] = data[k*8 +: 8];
      return r;
   endfunction

   function automatic logic [RC*DW-1:0] mdl_vec();
      logic [RC*DW-1:0] v;
      for (int i = 0; i < RC; i++) v[i*DW +: DW] = ROM[i] ? '0 : mdl[i];
      return v;
   endfunction

   always @(negedge PCLK) begin : mon
      exp_t e;
      if (!PRESETn) begin
         exp_pulse = '0;
         sb_q.delete();
      end else begin
         chk("wr_pulse", wr_pulse, exp_pulse);
         exp_pulse = '0;
         if (PREADY) begin
            if (sb_q.size() == 0) begin
               chk("unexpected_pready", PREADY, 1'b0);
            end else begin
               e = sb_q.pop_front();
               chk("pslverr", PSLVERR, e.err);
               if (!e.wr || e.err) chk("prdata", PRDATA, e.rdata);
               exp_pulse = e.pulse;
            end
         end
      end
   end

   task automatic xfer(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                       input logic [3:0] strb, input logic poke);
      exp_t e;
      int   idx;
      int   n;
      logic ro;
      logic err;
      idx   = int'(addr[AW-1:2]);
      ro    = (idx < RC) ? ROM[idx[3:0]] : 1'b0;
      err   = (idx >= RC) || (addr[1:0] != 2'b00) || (wr && ro);
      e.wr  = wr;
      e.err = err;
      e.rdata = err ? '0 : (ro ? hw_status[idx*DW +: DW] : mdl[idx[3:0]]);
      e.pulse = '0;
      if (wr && !err) e.pulse[idx[3:0]] = 1'b1;
      sb_q.push_back(e);
      @(posedge PCLK); #1;
      chk("reg_q", reg_q, mdl_vec());
      PSEL = 1'b1; PENABLE = 1'b0; PADDR = addr; PWRITE = wr; PWDATA = data; PSTRB = strb;
      @(posedge PCLK); #1;
      PENABLE = 1'b1;
      if (poke) hw_status[3*DW +: DW] = 32'h0BAD0BAD;
      n = 0;
      do begin
         @(negedge PCLK);
         n++;
      end while (!PREADY && n < 40);
      chk("latency", n, EXP_WS + 1);
      if (wr && !err) mdl[idx[3:0]] = merge(mdl[idx[3:0]], data, strb);
      if (poke) hw_status[3*DW +: DW] = HW3;
   endtask

   task automatic idle();
      @(posedge PCLK); #1;
      PSEL = 1'b0; PENABLE = 1'b0;
      chk("reg_q_idle", reg_q, mdl_vec());
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic          wr;
      int            idx;
      logic [AW-1:0] addr;
      PRESETn = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
      PADDR = '0; PWDATA = '0; PSTRB = '0;
      for (int i = 0; i < RC; i++) begin
         hw_status[i*DW +: DW] = $urandom;
         mdl[i] = '0;
      end
      hw_status[3*DW +: DW] = HW3;
      repeat (2) @(negedge PCLK);
      chk("rst_pready", PREADY, 1'b0);
      chk("rst_pslverr", PSLVERR, 1'b0);
      chk("rst_prdata", PRDATA, '0);
      chk("rst_wr_pulse", wr_pulse, '0);
      chk("rst_reg_q", reg_q, '0);
      @(posedge PCLK); #1;
      PRESETn = 1'b1;

      xfer(1'b1, 12'h004, 32'hDEADBEEF, 4'hF, 1'b0);
      xfer(1'b0, 12'h004, '0, 4'h0, 1'b0);
      xfer(1'b1, 12'h008, 32'h11223344, 4'hF, 1'b0);
      xfer(1'b1, 12'h008, 32'hAABBCCDD, 4'h5, 1'b0);
      xfer(1'b0, 12'h008, '0, 4'h0, 1'b0);
      xfer(1'b1, 12'h004, 32'h12345678, 4'h0, 1'b0);
      xfer(1'b0, 12'h004, '0, 4'h0, 1'b0);
      idle();

      xfer(1'b0, 12'h100, '0, 4'h0, 1'b0);
      xfer(1'b1, 12'h006, 32'h55555555, 4'hF, 1'b0);
      xfer(1'b0, 12'h004, '0, 4'h0, 1'b0);
      xfer(1'b0, 12'h00C, '0, 4'h0, 1'b1);
      xfer(1'b1, 12'h00C, 32'h99999999, 4'hF, 1'b0);
      xfer(1'b0, 12'h00C, '0, 4'h0, 1'b0);
      xfer(1'b0, 12'h03C, '0, 4'h0, 1'b0);
      xfer(1'b1, 12'h03C, 32'hF00DF00D, 4'hF, 1'b0);
      xfer(1'b0, 12'h03C, '0, 4'h0, 1'b0);

      // master abandons a write right after its setup cycle
      @(posedge PCLK); #1;
      PSEL = 1'b1; PENABLE = 1'b0; PADDR = 12'h010; PWRITE = 1'b1; PWDATA = 32'h77777777; PSTRB = 4'hF;
      @(posedge PCLK); #1;
      PSEL = 1'b0; PENABLE = 1'b0;
      repeat (3) @(posedge PCLK);
      xfer(1'b0, 12'h010, '0, 4'h0, 1'b0);
      idle();

      for (int t = 0; t < 16; t++) begin
         wr   = 1'($urandom_range(0, 1));
         idx  = $urandom_range(0, RC + 1);
         addr = AW'(idx * 4);
         if ($urandom_range(0, 7) == 0) addr[1] = 1'b1;
         xfer(wr, addr, $urandom, 4'($urandom_range(0, 15)), 1'b0);
      end
      idle();

      xfer(1'b1, 12'h014, 32'h01020304, 4'hF, 1'b0);
      @(posedge PCLK); #1;
      PSEL = 1'b1; PENABLE = 1'b0; PADDR = 12'h014; PWRITE = 1'b1; PWDATA = 32'h5A5A5A5A; PSTRB = 4'hF;
      @(posedge PCLK); #1;
      PENABLE = 1'b1;
      #1 PRESETn = 1'b0;
      #1;
      chk("arst_pready", PREADY, 1'b0);
      chk("arst_pslverr", PSLVERR, 1'b0);
      chk("arst_prdata", PRDATA, '0);
      chk("arst_wr_pulse", wr_pulse, '0);
      chk("arst_reg_q", reg_q, '0);
      for (int i = 0; i < RC; i++) mdl[i] = '0;
      PSEL = 1'b0; PENABLE = 1'b0;
      @(posedge PCLK); #1;
      PRESETn = 1'b1;
      xfer(1'b0, 12'h014, '0, 4'h0, 1'b0);
      xfer(1'b0, 12'h004, '0, 4'h0, 1'b0);
      idle();
      repeat (2) @(posedge PCLK);

      chk("sb_empty", sb_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/apb4_regbank.md
# apb4_regbank

Parametrised APB4 register bank: the next generation of the team's APB slave register file. It adds byte-lane write strobes, programmable wait states, read-only hardware-status registers, per-register write pulses, and correct APB error signalling in the completing access cycle. It sits behind the APB interconnect as a leaf slave. It exposes its register contents and write strobes to fabric logic.

## Interface
Parameters:
- DATA_WIDTH, 32: data bus width; multiple of 8.
- ADDR_WIDTH, 12: PADDR width.
- REG_COUNT, 16: number of word registers; index = PADDR[ADDR_WIDTH-1:2].
- RO_MASK, 0: REG_COUNT-bit mask; bit i set makes register i read-only, sourced from hw_status.
- WAIT_STATES, 0: extra access-phase cycles before PREADY; range 0..15.

Ports:
- PCLK  in  1  clock.
- PRESETn  in  1  reset, asynchronous, active-low.
- PADDR  in  ADDR_WIDTH  byte address.
- PSEL  in  1  slave select.
- PENABLE  in  1  access phase.
- PWRITE  in  1  1 = write.
- PWDATA  in  DATA_WIDTH  write data.
- PSTRB  in  DATA_WIDTH/8  byte-lane write enables.
- PRDATA  out  DATA_WIDTH  read data, registered.
- PREADY  out  1  transfer complete.
- PSLVERR  out  1  error response, valid only with PREADY.
- hw_status  in  REG_COUNT*DATA_WIDTH  read values for RO registers; register i occupies slice [i*DATA_WIDTH +: DATA_WIDTH].
- reg_q  out  REG_COUNT*DATA_WIDTH  current RW register contents; RO slots drive 0.
- wr_pulse  out  REG_COUNT  one-cycle pulse, registered, when register i is written.

## Operation
- FSM states:
  - IDLE: waits for a setup phase. IDLE->SETUP on PSEL & !PENABLE.
  - SETUP: one cycle, then SETUP->ACCESS.
  - ACCESS: holds while the wait counter is below WAIT_STATES. On completion, goes to SETUP if PSEL & !PENABLE, else IDLE.
- Setup-edge capture (clock edge leaving SETUP):
  - err_q = (index >= REG_COUNT) | (PADDR[1:0] != 0) | (PWRITE & RO_MASK[index]).
  - PRDATA is loaded on reads: hw_status slice if RO, else regfile[index]. PRDATA loads 0 if err_q.
- Wait counter: 4 bits; cleared in SETUP; increments each ACCESS cycle until it equals WAIT_STATES.
- PREADY = (state == ACCESS) & PSEL & PENABLE & (cnt == WAIT_STATES). It is combinational from registered state.
- PSLVERR = PREADY & err_q. It is 0 whenever PREADY is 0.
- Write commit on the edge where PREADY & PWRITE & !err_q:
  - regfile[index] byte k <= PWDATA byte k for each set PSTRB[k].
  - wr_pulse[index] = 1 for the next cycle.
- PSTRB = 0 on a write: no data change; wr_pulse still fires; no error.
- Errored writes never modify state and never pulse.
- Reads are side-effect free.
- PSEL dropped mid-access (protocol violation): FSM returns to IDLE, no commit.

## Timing
- Reset values: PRDATA 0, PSLVERR 0, PREADY 0, wr_pulse 0, all regfile entries 0, state IDLE, counter 0.
- Reset is asynchronous and takes effect immediately mid-transfer. An in-flight write is discarded.
- Zero wait states: the transfer completes in 2 cycles (setup plus one access), with PREADY high in the first ACCESS cycle.
- N wait states: PREADY rises after N+1 ACCESS cycles.
- Data visibility:
  - Written data is visible on reg_q one cycle after the commit edge.
  - A back-to-back read to the same register returns the new value.
  - hw_status is sampled at the setup edge only; later changes are not reflected in that transfer.

## Configuration
- APB_REGBANK_WAIT_EN:
  - Defined: the WAIT_STATES parameter and the counter are compiled in.
  - Undefined: the counter is removed, PREADY ignores WAIT_STATES, and every access completes with zero wait.

## Structure
- Package apb_regbank_pkg: FSM state enum (IDLE, SETUP, ACCESS), the 2'b00 byte-offset check constant, and an index-width function clog2(REG_COUNT).
- One sub-module, apb_wait_counter: clear, enable, terminal count, done output. It is instantiated only under APB_REGBANK_WAIT_EN.

## Test plan
- Reset, then a zero-wait write of 0xDEADBEEF to 0x004 with PSTRB=0xF, then a read of 0x004:
  - PREADY high in the second cycle of each transfer.
  - PRDATA = 0xDEADBEEF, PSLVERR 0.
  - wr_pulse[1] high for exactly one cycle.
- Write 0x11223344 to 0x008, then 0xAABBCCDD with PSTRB=0x5 -> read returns 0x11BB33DD.
- Read of 0x100 with REG_COUNT=16, and a write to misaligned address 0x006:
  - PSLVERR=1 with PREADY; PRDATA 0.
  - No regfile change and no wr_pulse.
- RO_MASK bit 3 set, hw_status slot 3 = 0xCAFE0003:
  - Read 0x00C returns 0xCAFE0003.
  - Write 0x00C gives PSLVERR=1 and the value is unchanged.
- WAIT_STATES=3 with APB_REGBANK_WAIT_EN defined -> PREADY rises on the 4th ACCESS cycle; write commits only on that edge.
- PRESETn asserted during the ACCESS wait of a write:
  - All outputs read 0 immediately.
  - The target register stays 0 after reset release.
